// File: rtl/systolic_pkg.sv
// Shared FSM state type and requantise/saturate helper for the systolic array.
package systolic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_e;

    localparam int RQ_W = 64;

    // acc must arrive already sign-extended from accu_w bits; the wide datapath
    // holds acc + 2^(s-1) without overflow for any s <= accu_w-1.
    function automatic logic signed [RQ_W-1:0] requant_sat(
        input logic signed [RQ_W-1:0] acc,
        input logic [7:0]             shift,
        input int                     accu_w,
        input int                     act_w
    );
        int                     s;
        logic signed [RQ_W-1:0] v;
        logic signed [RQ_W-1:0] hi;
        logic signed [RQ_W-1:0] lo;
        s = (int'(shift) >= accu_w) ? accu_w - 1 : int'(shift);
        if (s == 0) v = acc;
        else        v = (acc + (64'sd1 <<< (s - 1))) >>> s;
        hi = (64'sd1 <<< (act_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        else             return v;
    endfunction

endpackage

// File: rtl/systolic_pe_v2.sv
// One processing element: held activation, signed multiply, and a registered
// partial sum that extends the chain from the previous element.
module systolic_pe_v2
    import systolic_pkg::*;
#(
    parameter int BW_ACT  = 8,
    parameter int BW_WET  = 8,
    parameter int BW_ACCU = 32
)(
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      en,
    input  logic                      load_act,
    input  logic signed [BW_ACT-1:0]  act_in,
    input  logic signed [BW_WET-1:0]  wet_in,
    input  logic signed [BW_ACCU-1:0] psum_in,
    output logic signed [BW_ACCU-1:0] psum_out
);

    logic signed [BW_ACT-1:0]        act_q;
    logic signed [BW_ACT+BW_WET-1:0] prod;

    assign prod = act_q * wet_in;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_q    <= '0;
            psum_out <= '0;
        end else begin
            if (load_act) act_q <= act_in;
            if (en)       psum_out <= psum_in + BW_ACCU'(prod);
        end
    end

endmodule

// File: rtl/systolic_array_v2.sv
// Weight-streaming systolic dot-product array: one weight row in, one
// requantised result out, with a single stall that freezes the whole pipe.
module systolic_array_v2
    import systolic_pkg::*;
#(
    parameter int ACCU_NUM = 4,
    parameter int MAC_NUM  = 8,
    parameter int BW_ACT   = 8,
    parameter int BW_WET   = 8,
    parameter int BW_ACCU  = 32
)(
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             start,
    output logic                             start_ready,
    input  logic [ACCU_NUM-1:0][BW_ACT-1:0]  act_in,
    input  logic [7:0]                       shift_num,
    input  logic                             wet_valid,
    output logic                             wet_ready,
    input  logic [ACCU_NUM-1:0][BW_WET-1:0]  wet_in,
    output logic                             res_valid,
    input  logic                             res_ready,
    output logic signed [BW_ACT-1:0]         res_data,
    output logic                             res_last,
    output logic                             done,
    output state_e                           state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never waits on ready, and res_* hold while valid & !ready.

    localparam int               CNT_W    = $clog2(MAC_NUM + 1);
    localparam logic [CNT_W-1:0] N_ROWS   = CNT_W'(MAC_NUM);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(MAC_NUM - 1);

    state_e                               state, state_d;
    logic [CNT_W-1:0]                     row_cnt;
    logic [7:0]                           shift_q;
    logic                                 stall, en;
    logic                                 start_fire, wet_fire, res_fire;
    logic [ACCU_NUM:0]                    vld_pipe, last_pipe;
    logic [ACCU_NUM-1:0][BW_ACCU-1:0]     psum;
    logic signed [BW_ACCU-1:0]            psum_last;
    logic signed [BW_ACT-1:0]             res_next;

    assign stall       = res_valid & ~res_ready;
    assign en          = ~stall;
    assign start_ready = (state == ST_IDLE);
    assign start_fire  = start & start_ready;
    assign wet_ready   = (state == ST_COMPUTE) && (row_cnt < N_ROWS) && !stall;
    assign wet_fire    = wet_valid & wet_ready;
    assign res_fire    = res_valid & res_ready;
    assign state_dbg   = state;

    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:    if (start_fire) state_d = ST_COMPUTE;
            ST_COMPUTE: if (wet_fire && row_cnt == LAST_ROW) state_d = ST_DRAIN;
            ST_DRAIN:   if (res_fire && res_last) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            row_cnt <= '0;
            shift_q <= '0;
            done    <= 1'b0;
        end else begin
            state <= state_d;
            done  <= res_fire & res_last;
            if (start_fire) begin
                row_cnt <= '0;
                shift_q <= shift_num;
            end else if (wet_fire) begin
                row_cnt <= row_cnt + CNT_W'(1);
            end
        end
    end

    // Valid/last tags travel alongside the data; index ACCU_NUM lines up with
    // the final PE's registered sum.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
        end else if (en) begin
            vld_pipe  <= {vld_pipe[ACCU_NUM-1:0], wet_fire};
            last_pipe <= {last_pipe[ACCU_NUM-1:0], wet_fire && (row_cnt == LAST_ROW)};
        end
    end

    for (genvar k = 0; k < ACCU_NUM; k++) begin : g_col
        logic [BW_WET-1:0]         skew [0:k];
        logic signed [BW_ACCU-1:0] psum_prev;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int d = 0; d <= k; d++) skew[d] <= '0;
            end else if (en) begin
                skew[0] <= wet_fire ? wet_in[k] : '0;
                for (int d = 1; d <= k; d++) skew[d] <= skew[d-1];
            end
        end

        if (k == 0) begin : g_first
            assign psum_prev = '0;
        end else begin : g_chain
            assign psum_prev = psum[k-1];
        end

        systolic_pe_v2 #(
            .BW_ACT  (BW_ACT),
            .BW_WET  (BW_WET),
            .BW_ACCU (BW_ACCU)
        ) u_pe (
            .clk      (clk),
            .reset_n  (reset_n),
            .en       (en),
            .load_act (start_fire),
            .act_in   (act_in[k]),
            .wet_in   (skew[k]),
            .psum_in  (psum_prev),
            .psum_out (psum[k])
        );
    end

    assign psum_last = psum[ACCU_NUM-1];
    assign res_next  = BW_ACT'(requant_sat(RQ_W'(psum_last), shift_q, BW_ACCU, BW_ACT));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_last  <= 1'b0;
        end else if (en) begin
            res_valid <= vld_pipe[ACCU_NUM];
            res_data  <= res_next;
            res_last  <= vld_pipe[ACCU_NUM] & last_pipe[ACCU_NUM];
        end
    end

endmodule

// File: tb/tb_systolic_array_v2.sv
// Randomised and directed bench for systolic_array_v2 (K=4, N=3) with a
// dot-product/requant reference model and a per-cycle output checker.
module tb_systolic_array_v2;

    localparam int K       = 4;
    localparam int N       = 3;
    localparam int BW_ACT  = 8;
    localparam int BW_WET  = 8;
    localparam int BW_ACCU = 32;

    logic                          clk = 1'b0;
    logic                          reset_n = 1'b0;
    logic                          start = 1'b0;
    logic                          start_ready;
    logic [K-1:0][BW_ACT-1:0]      act_in = '0;
    logic [7:0]                    shift_num = '0;
    logic                          wet_valid = 1'b0;
    logic                          wet_ready;
    logic [K-1:0][BW_WET-1:0]      wet_in = '0;
    logic                          res_valid;
    logic                          res_ready = 1'b0;
    logic signed [BW_ACT-1:0]      res_data;
    logic                          res_last;
    logic                          done;
    logic [1:0]                    state_dbg;

    systolic_array_v2 #(
        .ACCU_NUM (K),
        .MAC_NUM  (N),
        .BW_ACT   (BW_ACT),
        .BW_WET   (BW_WET),
        .BW_ACCU  (BW_ACCU)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .start_ready (start_ready),
        .act_in      (act_in),
        .shift_num   (shift_num),
        .wet_valid   (wet_valid),
        .wet_ready   (wet_ready),
        .wet_in      (wet_in),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_last    (res_last),
        .done        (done),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int                        checks = 0;
    int                        errors = 0;
    logic signed [BW_ACT-1:0]  exp_q[$];
    logic                      exp_last_q[$];
    int                        got_q[$];
    int                        vis_cyc_q[$];
    int                        acc_cyc_q[$];
    int                        done_cyc = -1;
    int                        m_act[K];
    int                        m_shift = 0;
    int                        m_phase = 0;   // 0 idle, 1 taking rows, 2 draining
    int                        m_rows = 0;
    logic                      done_exp = 1'b0;
    logic                      front_seen = 1'b0;
    logic                      rr_rand = 1'b0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: wrap the dot product to 32 bits, round-half-up shift, clamp to int8.
    function automatic int model_rq(input longint acc, input int sh);
        longint v;
        int     s;
        s = (sh > BW_ACCU - 1) ? BW_ACCU - 1 : sh;
        if (s == 0) v = acc;
        else        v = (acc + (longint'(1) << (s - 1))) >>> s;
        if (v > 127)  v = 127;
        if (v < -128) v = -128;
        return int'(v);
    endfunction

    function automatic longint model_dot();
        longint s;
        s = 0;
        for (int k = 0; k < K; k++) s += longint'(m_act[k]) * longint'($signed(wet_in[k]));
        return longint'(int'(s));
    endfunction

    // ---------------- monitor / compare ----------------
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            exp_last_q.delete();
            m_phase    = 0;
            m_rows     = 0;
            done_exp   = 1'b0;
            front_seen = 1'b0;
        end else begin
            check("done", done, done_exp);
            check("start_ready", start_ready, m_phase == 0);
            check("wet_ready", wet_ready, (m_phase == 1) && (m_rows < N) && !(res_valid && !res_ready));
            if (done) done_cyc = cyc;
            done_exp = 1'b0;
            if (res_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL res_unexpected: got data %0d with no result pending (cycle %0d)", res_data, cyc);
                end else begin
                    check("res_data", res_data, exp_q[0]);
                    check("res_last", res_last, exp_last_q[0]);
                    if (!front_seen) begin
                        vis_cyc_q.push_back(cyc);
                        front_seen = 1'b1;
                    end
                    if (res_ready) begin
                        got_q.push_back(int'(res_data));
                        if (exp_last_q[0]) begin
                            done_exp = 1'b1;
                            m_phase  = 0;
                        end
                        void'(exp_q.pop_front());
                        void'(exp_last_q.pop_front());
                        front_seen = 1'b0;
                    end
                end
            end
            if (start && start_ready) begin
                for (int k = 0; k < K; k++) m_act[k] = $signed(act_in[k]);
                m_shift = int'(shift_num);
                m_phase = 1;
                m_rows  = 0;
            end else if (wet_valid && wet_ready) begin
                exp_q.push_back(BW_ACT'(model_rq(model_dot(), m_shift)));
                m_rows++;
                exp_last_q.push_back(m_rows == N);
                acc_cyc_q.push_back(cyc + 1);
                if (m_rows == N) m_phase = 2;
            end
        end
    end

    always @(posedge clk) begin
        if (rr_rand) begin
            #1;
            res_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_job(input int a[K], input int sh);
        @(posedge clk); #1;
        for (int k = 0; k < K; k++) act_in[k] = BW_ACT'(a[k]);
        shift_num = 8'(sh);
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        act_in    = K*BW_ACT'($urandom);
        shift_num = 8'($urandom);
    endtask

    // Called at posedge+1; returns at posedge+1 just after the handshake edge.
    task automatic send_row(input int w[K]);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < K; k++) wet_in[k] = BW_WET'(w[k]);
        wet_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (wet_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL row_timeout: wet_ready never rose (cycle %0d)", cyc);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_done(input int bound);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done within %0d cycles (cycle %0d)", bound, cyc);
        end
        @(posedge clk); #1;
    endtask

    task automatic clear_logs();
        got_q.delete();
        vis_cyc_q.delete();
        acc_cyc_q.delete();
        done_cyc = -1;
    endtask

    task automatic check_results(input string name, input int e0, input int e1, input int e2);
        check({name, "_count"}, got_q.size(), 3);
        if (got_q.size() == 3) begin
            check({name, "_r0"}, got_q[0], e0);
            check({name, "_r1"}, got_q[1], e1);
            check({name, "_r2"}, got_q[2], e2);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        int nvalid;
        logic seen;

        // model pins
        check("model_pass", model_rq(10, 0), 10);
        check("model_sat_hi", model_rq(1270, 0), 127);
        check("model_sat_lo", model_rq(-1000, 0), -128);
        check("model_round_pos", model_rq(10, 2), 3);
        check("model_round_neg", model_rq(-10, 2), -2);
        check("model_big_shift", model_rq(-1, 40), 0);

        // reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_last", res_last, 0);
        check("rst_done", done, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_start_ready", start_ready, 1);
        check("post_rst_wet_ready", wet_ready, 0);
        @(posedge clk); #1;

        // back-to-back rows, shift 0, saturation and latency
        res_ready = 1'b1;
        clear_logs();
        start_job('{1, 2, 3, 4}, 0);
        send_row('{1, 1, 1, 1});
        send_row('{-1, -1, -1, -1});
        send_row('{127, 127, 127, 127});
        wet_valid = 1'b0;
        wait_done(100);
        check_results("basic", 10, -10, 127);
        if (acc_cyc_q.size() == 3 && vis_cyc_q.size() == 3) begin
            check("b2b_rows", acc_cyc_q[2] - acc_cyc_q[0], 2);
            check("lat_r0", vis_cyc_q[0], acc_cyc_q[0] + 5);
            check("lat_r1", vis_cyc_q[1], acc_cyc_q[0] + 6);
            check("lat_r2", vis_cyc_q[2], acc_cyc_q[0] + 7);
            check("lat_done", done_cyc, acc_cyc_q[0] + 8);
        end else begin
            check("lat_logs", vis_cyc_q.size(), 3);
        end

        // rounding shift
        clear_logs();
        start_job('{1, 2, 3, 4}, 2);
        send_row('{1, 1, 1, 1});
        send_row('{-1, -1, -1, -1});
        send_row('{5, 5, 5, 5});
        wet_valid = 1'b0;
        wait_done(100);
        check_results("shift2", 3, -2, 13);

        // output stall freezes everything
        clear_logs();
        res_ready = 1'b0;
        start_job('{1, 2, 3, 4}, 0);
        send_row('{2, 2, 2, 2});
        wet_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (res_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("stall_first_valid", seen, 1);
        @(posedge clk); #1;
        for (int k = 0; k < K; k++) wet_in[k] = BW_WET'(-3);
        wet_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_hold_data", res_data, 20);
            check("stall_hold_valid", res_valid, 1);
            check("stall_wet_ready", wet_ready, 0);
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        send_row('{-3, -3, -3, -3});
        send_row('{1, 0, 0, 0});
        wet_valid = 1'b0;
        wait_done(100);
        check_results("stall", 20, -30, 1);

        // start during drain is ignored
        clear_logs();
        start_job('{1, 2, 3, 4}, 1);
        send_row('{1, 1, 1, 1});
        send_row('{3, 0, 0, 0});
        send_row('{0, 0, 0, -1});
        wet_valid = 1'b0;
        for (int k = 0; k < K; k++) act_in[k] = BW_ACT'(9);
        shift_num = 8'd0;
        start     = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(100);
        check_results("drain_start", 5, 2, -2);

        // reset mid-compute drops the job
        clear_logs();
        start_job('{7, -7, 5, 3}, 0);
        send_row('{4, 4, 4, 4});
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        check("mid_rst_res_valid", res_valid, 0);
        check("mid_rst_res_data", res_data, 0);
        check("mid_rst_res_last", res_last, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_wet_ready", wet_ready, 0);
        wet_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        nvalid = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) check("mid_rst_start_ready", start_ready, 1);
            if (res_valid) nvalid++;
        end
        check("mid_rst_no_stale", nvalid, 0);
        @(posedge clk); #1;

        // randomised jobs with random back-pressure
        rr_rand = 1'b1;
        for (int j = 0; j < 25; j++) begin : rnd_job
            int a[K];
            int w[K];
            int sh;
            int gap;
            for (int k = 0; k < K; k++) a[k] = int'($urandom_range(0, 255)) - 128;
            sh = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 12));
            start_job(a, sh);
            for (int r = 0; r < N; r++) begin
                gap = int'($urandom_range(0, 2));
                repeat (gap) begin
                    wet_valid = 1'b0;
                    @(posedge clk); #1;
                end
                for (int k = 0; k < K; k++) w[k] = int'($urandom_range(0, 255)) - 128;
                send_row(w);
            end
            wet_valid = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < K; k++) act_in[k] = BW_ACT'($urandom);
                shift_num = 8'($urandom);
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
            wait_done(600);
        end
        rr_rand = 1'b0;
        @(posedge clk); #2;
        res_ready = 1'b1;
        repeat (4) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/systolic_array_v2.md
SYSTOLIC_ARRAY_V2 -- requirements
Module: systolic_array_v2

Interface
REQ-001 SHALL have parameter ACCU_NUM, default 4: PE chain length K (>=2).
REQ-002 SHALL have parameter MAC_NUM, default 8: output results N per job (>=1).
REQ-003 SHALL have parameters BW_ACT=8, BW_WET=8, BW_ACCU=32: activation, weight and accumulator widths.
REQ-004 SHALL have port clk, input, 1, the clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, job request; accepted only when start_ready=1.
REQ-007 SHALL have port start_ready, output, 1, high in IDLE.
REQ-008 SHALL have port act_in, input, K x BW_ACT signed, activation vector captured on start.
REQ-009 SHALL have port shift_num, input, 8, requant shift captured on start.
REQ-010 SHALL have ports wet_valid (input, 1), wet_ready (output, 1), wet_in (input, K x BW_WET signed): one weight row per handshake.
REQ-011 SHALL have ports res_valid (output, 1), res_ready (input, 1), res_data (output, BW_ACT signed), res_last (output, 1): result stream.
REQ-012 SHALL have port done, output, 1, one-cycle pulse at job end.

Function
REQ-013 SHALL implement FSM IDLE -> COMPUTE on start&start_ready; COMPUTE -> DRAIN after the N-th weight handshake; DRAIN -> IDLE on the N-th result handshake.
REQ-014 SHALL assert wet_ready only in COMPUTE, while fewer than N rows are accepted and the array is not stalled.
REQ-015 SHALL compute result n = sum over k of act[k]*w[n][k]; weight element k is delayed k cycles and PE k adds its product to PE k-1's registered partial sum.
REQ-016 SHALL sign-extend each BW_ACT+BW_WET product to BW_ACCU; accumulation wraps modulo 2^BW_ACCU.
REQ-017 SHALL requantise: shift 0 passes unchanged; otherwise (acc + 2^(shift-1)) arithmetic-shifted right by shift, computed in BW_ACCU+1 bits; shift >= BW_ACCU clamps to BW_ACCU-1.
REQ-018 SHALL saturate the requantised value to [-2^(BW_ACT-1), 2^(BW_ACT-1)-1].
REQ-019 SHALL present a row accepted at edge t as res_valid at t+K+1 when unstalled.
REQ-020 SHALL stall the entire pipeline, skew registers and counters while res_valid=1 and res_ready=0; res_data/res_last hold stable and no result is lost, duplicated or reordered.
REQ-021 SHALL sustain one row per cycle and one result per cycle when unstalled.
REQ-022 SHALL assert res_last with the N-th result of the job only.
REQ-023 SHALL pulse done in the cycle after the N-th result handshake, with the FSM already in IDLE.
REQ-024 SHALL ignore start outside IDLE and ignore wet_valid when wet_ready=0.

Reset
REQ-025 SHALL on reset_n=0 immediately clear FSM to IDLE, all counters, PE and skew registers, res_valid, res_data, res_last and done to 0; start_ready=1 after release.
REQ-026 SHALL drop any in-flight job on reset mid-operation with no result emitted afterwards.

Structure
REQ-027 SHALL place the state enum and the requant/saturate function in package systolic_pkg.
REQ-028 SHALL instantiate K copies of sub-module systolic_pe_v2 (activation register, multiply, add, enable).

Verification (K=4, N=3, 8/8/32)
REQ-029 act=[1,2,3,4], rows [1,1,1,1],[-1,-1,-1,-1],[127,127,127,127], shift 0 -> 10, -10, 127 (saturated from 1270), res_last on third.
REQ-030 Same acts, row [1,1,1,1], shift 2 -> (10+2)>>2 = 3; row [-1,...] -> -2.
REQ-031 res_ready low 5 cycles at first res_valid -> res_data stable, wet_ready low, all 3 results in order.
REQ-032 Back-to-back rows from edge t, res_ready=1 -> results at t+5, t+6, t+7; done at t+8.
REQ-033 reset_n low mid-COMPUTE -> outputs 0 at once; start_ready=1 after release; no stale result.
REQ-034 start pulsed during DRAIN -> ignored; acts and shift unchanged.
